// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store; data side has priority.
// Optional MEM_ARB_STATS_EN adds a saturating fetch/data conflict counter with synchronous clear.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_f,
  output logic              stall_m,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_grant_dm;
  logic   w_grant_if;
  logic   w_ack_busy;
  logic   r_served_dm;

  assign busy       = (r_state == BUSY_IF) || (r_state == BUSY_DM);
  assign w_ack_busy = busy & mem_ack;
  assign stall_f    = if_req & ~if_valid;
  assign stall_m    = dm_req & ~dm_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode; RESP excludes the side whose req is still up from the finished access
  always_comb begin
    w_state_nxt = r_state;
    w_grant_dm  = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      IDLE: begin
        if (dm_req) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = BUSY_DM;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      RESP: begin
        if (r_served_dm) begin
          if (if_req) begin
            w_grant_if  = 1'b1;
            w_state_nxt = BUSY_IF;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (dm_req) begin
            w_grant_dm  = 1'b1;
            w_state_nxt = BUSY_DM;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Memory-side request fields and requester responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      if_rdata    <= {DATA_W{1'b0}};
      dm_rdata    <= {DATA_W{1'b0}};
      if_valid    <= 1'b0;
      dm_valid    <= 1'b0;
      r_served_dm <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (w_grant_dm) begin
        mem_req     <= 1'b1;
        mem_we      <= dm_we;
        mem_addr    <= dm_addr;
        mem_wdata   <= dm_wdata;
        r_served_dm <= 1'b1;
      end else if (w_grant_if) begin
        mem_req     <= 1'b1;
        mem_we      <= 1'b0;
        mem_addr    <= if_addr;
        r_served_dm <= 1'b0;
      end else if (w_ack_busy) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (r_served_dm) begin
          dm_valid <= 1'b1;
          // stores leave the last load data untouched
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating conflict counter, clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      conflict_cnt <= {CNT_W{1'b0}};
    end else if (if_req && dm_req && (stall_f || stall_m) && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked on the falling clock edge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_f, stall_m, busy;
`ifdef MEM_ARB_STATS_EN
  logic        stat_clr;
  logic [3:0]  conflict_cnt;
`endif
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32)
`ifdef MEM_ARB_STATS_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .stat_clr(stat_clr), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  // Latched request fields must stay put while a request is outstanding
  logic        r_prev_req = 1'b0;
  logic        r_prev_we;
  logic [31:0] r_prev_addr, r_prev_wdata;
  always @(negedge clk) begin
    if (!rst && r_prev_req && mem_req) begin
      chk("stable_addr", mem_addr, r_prev_addr);
      chk("stable_wdata", mem_wdata, r_prev_wdata);
      chk("stable_we", {31'd0, mem_we}, {31'd0, r_prev_we});
    end
    r_prev_req   = mem_req;
    r_prev_we    = mem_we;
    r_prev_addr  = mem_addr;
    r_prev_wdata = mem_wdata;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; mem_rdata = 32'd0;
`ifdef MEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    nc(); nc();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // 1: fetch only, L=0
    nc();
    if_req = 1'b1; if_addr = 32'h0040_0000; #1;
    chk("t1_stall_f_N", {31'd0, stall_f}, 32'd1);
    chk("t1_mem_req_N", {31'd0, mem_req}, 32'd0);
    nc();
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h0040_0000);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_stall_f_N1", {31'd0, stall_f}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    nc();
    mem_ack = 1'b0;
    chk("t1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    chk("t1_stall_f_N2", {31'd0, stall_f}, 32'd0);
    chk("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
    if_req = 1'b0;
    nc();
    chk("t1_if_valid_pulse", {31'd0, if_valid}, 32'd0);
    chk("t1_idle", {30'd0, busy, mem_req}, 32'd0);

    // fetch withdrawn after issue still completes
    if_req = 1'b1; if_addr = 32'h0040_000C;
    nc();
    chk("wd_mem_req", {31'd0, mem_req}, 32'd1);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_006F;
    nc();
    mem_ack = 1'b0;
    chk("wd_if_valid", {31'd0, if_valid}, 32'd1);
    chk("wd_if_rdata", if_rdata, 32'h0000_006F);

    // 2: load, L=3
    nc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0010; #1;
    chk("t2_stall_m_N", {31'd0, stall_m}, 32'd1);
    nc();
    chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t2_mem_addr", mem_addr, 32'h1000_0010);
    nc();
    chk("t2_stall_m_N2", {31'd0, stall_m}, 32'd1);
    nc();
    chk("t2_mem_req_N3", {31'd0, mem_req}, 32'd1);
    nc();
    chk("t2_stall_m_N4", {31'd0, stall_m}, 32'd1);
    chk("t2_dm_valid_early", {31'd0, dm_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    nc();
    mem_ack = 1'b0;
    chk("t2_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t2_stall_m_N5", {31'd0, stall_m}, 32'd0);
    dm_req = 1'b0;
    nc();
    chk("t2_dm_valid_pulse", {31'd0, dm_valid}, 32'd0);

    // 3: conflict, store first then fetch straight from RESP, L=1
    if_req = 1'b1; if_addr = 32'h0040_0004;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1000_0000; dm_wdata = 32'h1234_5678; #1;
    chk("t3_stalls_N", {30'd0, stall_f, stall_m}, 32'd3);
    nc();
    chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t3_mem_addr", mem_addr, 32'h1000_0000);
    chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    nc();
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    nc();
    mem_ack = 1'b0;
    chk("t3_dm_valid", {31'd0, dm_valid}, 32'd1);
    chk("t3_store_keeps_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t3_stall_f_resp", {31'd0, stall_f}, 32'd1);
    chk("t3_if_valid_resp", {31'd0, if_valid}, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    nc();
    chk("t3_fetch_no_gap", {31'd0, mem_req}, 32'd1);
    chk("t3_fetch_we", {31'd0, mem_we}, 32'd0);
    chk("t3_fetch_addr", mem_addr, 32'h0040_0004);
    nc();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    nc();
    mem_ack = 1'b0;
    chk("t3_if_valid_L2", {31'd0, if_valid}, 32'd1);
    chk("t3_if_rdata", if_rdata, 32'h0000_0013);
    if_req = 1'b0;
    nc();

    // 4: back-to-back loads, fetch pending at the first RESP
    dm_req = 1'b1; dm_addr = 32'h1000_0020;
    nc();
    chk("t4_load1_addr", mem_addr, 32'h1000_0020);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    nc();
    mem_ack = 1'b0;
    chk("t4_load1_valid", {31'd0, dm_valid}, 32'd1);
    chk("t4_load1_rdata", dm_rdata, 32'h1111_1111);
    if_req = 1'b1; if_addr = 32'h0040_0008;
    nc();
    chk("t4_no_dup_req", {31'd0, mem_req}, 32'd1);
    chk("t4_no_dup_addr", mem_addr, 32'h0040_0008);
    dm_addr = 32'h1000_0024; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    nc();
    mem_ack = 1'b0;
    chk("t4_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h2222_2222);
    chk("t4_dm_valid_quiet", {31'd0, dm_valid}, 32'd0);
    if_req = 1'b0;
    nc();
    chk("t4_load2_addr", mem_addr, 32'h1000_0024);
    chk("t4_load2_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    nc();
    mem_ack = 1'b0;
    chk("t4_load2_rdata", dm_rdata, 32'h3333_3333);
    dm_req = 1'b0;
    nc();
    chk("t4_idle", {30'd0, busy, mem_req}, 32'd0);

    // stray ack while idle
    mem_ack = 1'b1;
    nc();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {28'd0, busy, mem_req, if_valid, dm_valid}, 32'd0);

    // 5: reset in the middle of a data access
    dm_req = 1'b1; dm_addr = 32'h1000_0030;
    nc();
    chk("t5_busy_dm", {30'd0, busy, mem_req}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_drop", {30'd0, busy, mem_req}, 32'd0);
    nc();
    rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b1;
    nc();
    mem_ack = 1'b0;
    chk("t5_no_dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("t5_still_idle", {30'd0, busy, mem_req}, 32'd0);
    chk("t5_dm_rdata_reset", dm_rdata, 32'd0);

`ifdef MEM_ARB_STATS_EN
    // 6: conflict counter saturation and clear
    chk("t6_cnt_reset", {28'd0, conflict_cnt}, 32'd0);
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    for (int i = 0; i < 5; i++) nc();
    chk("t6_cnt_5", {28'd0, conflict_cnt}, 32'd5);
    for (int i = 0; i < 15; i++) nc();
    chk("t6_cnt_sat", {28'd0, conflict_cnt}, 32'h0000_000F);
    stat_clr = 1'b1;
    nc();
    chk("t6_cnt_clr", {28'd0, conflict_cnt}, 32'd0);
    stat_clr = 1'b0;
    nc();
    chk("t6_cnt_after_clr", {28'd0, conflict_cnt}, 32'd1);
    if_req = 1'b0; dm_req = 1'b0; rst = 1'b1;
    nc();
    rst = 1'b0;
`endif

    nc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
